// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
package mips_pkg;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] addr_t;

  localparam addr_t  WORD_BYTES       = 32'd4;
  localparam instr_t NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
  localparam addr_t  RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: decode control in, imem address/data, IF/ID outputs.
interface instruction_fetch_unit_if;
  import mips_pkg::*;

  logic   stall;
  logic   redirect;
  addr_t  redirect_target;
  addr_t  imem_addr;
  instr_t imem_rdata;
  instr_t id_instr;
  addr_t  id_pc;
  addr_t  id_pc_plus4;
  logic   id_valid;

  // Fetch unit side.
  modport master (
    input  stall, redirect, redirect_target, imem_rdata,
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid
  );

  // Environment side: decode control, memory and IF/ID consumer.
  modport slave (
    output stall, redirect, redirect_target, imem_rdata,
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid
  );

endinterface

// File: rtl/pc_next_logic.sv
// Next-PC selection and instruction-memory address mux.
module pc_next_logic
  import mips_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic  rst,
  input  logic  stall,
  input  logic  redirect,
  input  addr_t redirect_target,
  input  addr_t pc_q,
  input  addr_t inflight_pc_q,
  output addr_t pc_d,
  output addr_t imem_addr
);

  addr_t target_aligned;

  // Redirect beats stall; a stall replays the in-flight address so the
  // memory keeps returning the word that is waiting to enter IF/ID.
  always_comb begin
    target_aligned = {redirect_target[31:2], 2'b00};
    if (redirect)   pc_d = target_aligned;
    else if (stall) pc_d = pc_q;
    else            pc_d = pc_q + WORD_BYTES;  // wraps modulo 2^32

    if (rst)                     imem_addr = RESET_PC;
    else if (stall && !redirect) imem_addr = inflight_pc_q;
    else                         imem_addr = pc_q;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: PC, in-flight fetch tracking and the IF/ID register.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter addr_t  RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
  parameter instr_t NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);

  addr_t  pc_q, pc_d;
  addr_t  inflight_pc_q, inflight_pc_d;
  logic   inflight_valid_q, inflight_valid_d;
  instr_t id_instr_q, id_instr_d;
  addr_t  id_pc_q, id_pc_d;
  addr_t  id_pc_plus4_q, id_pc_plus4_d;
  logic   id_valid_q, id_valid_d;

  pc_next_logic #(.RESET_PC(RESET_PC)) u_pc_next (
    .rst             (rst),
    .stall           (bus.stall),
    .redirect        (bus.redirect),
    .redirect_target (bus.redirect_target),
    .pc_q            (pc_q),
    .inflight_pc_q   (inflight_pc_q),
    .pc_d            (pc_d),
    .imem_addr       (bus.imem_addr)
  );

  // IF/ID and in-flight next state: flush on redirect, hold on stall,
  // otherwise shift the returning word into IF/ID. An empty slot always
  // carries NOP so decode never sees stale data.
  always_comb begin
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    id_instr_d       = id_instr_q;
    id_pc_d          = id_pc_q;
    id_pc_plus4_d    = id_pc_plus4_q;
    id_valid_d       = id_valid_q;
    if (bus.redirect) begin
      inflight_valid_d = 1'b0;
      id_valid_d       = 1'b0;
      id_instr_d       = NOP_INSTR;
    end else if (!bus.stall) begin
      id_instr_d       = inflight_valid_q ? bus.imem_rdata : NOP_INSTR;
      id_pc_d          = inflight_pc_q;
      id_pc_plus4_d    = inflight_pc_q + WORD_BYTES;
      id_valid_d       = inflight_valid_q;
      inflight_pc_d    = pc_q;
      inflight_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      inflight_pc_q    <= RESET_PC;
      inflight_valid_q <= 1'b0;
      id_instr_q       <= NOP_INSTR;
      id_pc_q          <= '0;
      id_pc_plus4_q    <= WORD_BYTES;
      id_valid_q       <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      id_instr_q       <= id_instr_d;
      id_pc_q          <= id_pc_d;
      id_pc_plus4_q    <= id_pc_plus4_d;
      id_valid_q       <= id_valid_d;
    end
  end

  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_valid    = id_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random
// stall/redirect/reset traffic against an in-order fetch-stream model.
module tb_instruction_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad   = 0;

  // Stream model: next address ID will receive, bubbles before it, and
  // the expected IF/ID contents.
  logic [31:0] m_next;
  int          m_bub;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h2108_0008;
      32'd4:   return 32'h2129_0009;
      32'd8:   return 32'h0000_0000;
      32'd20:  return 32'h8D28_0018;
      32'd36:  return 32'hAD68_0018;
      default: return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endcase
  endfunction

  // One-cycle registered instruction memory.
  always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied,
  // then let the DUT take the same edge.
  task automatic tick();
    if (rst) begin
      m_next = RESET_PC_DEFAULT; m_bub = 1; m_valid = 1'b0; m_instr = NOP_INSTR;
    end else if (bus.redirect) begin
      m_next = bus.redirect_target & 32'hFFFF_FFFC; m_bub = 1;
      m_valid = 1'b0; m_instr = NOP_INSTR;
    end else if (!bus.stall) begin
      if (m_bub > 0) begin
        m_bub--; m_valid = 1'b0; m_instr = NOP_INSTR;
      end else begin
        m_valid = 1'b1; m_pc = m_next; m_instr = mem_word(m_next);
        m_next = m_next + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag);
    chk({tag, ".valid"}, {31'd0, bus.id_valid}, {31'd0, m_valid});
    chk({tag, ".instr"}, bus.id_instr, m_instr);
    if (m_valid) begin
      chk({tag, ".pc"}, bus.id_pc, m_pc);
      chk({tag, ".pc4"}, bus.id_pc_plus4, m_pc + 32'd4);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b1;          // must be ignored under reset
    bus.redirect_target = 32'd100;
    m_next = '0; m_bub = 1; m_valid = 1'b0; m_pc = '0; m_instr = NOP_INSTR;
    tick();
    tick();
    chk("rst.valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst.instr", bus.id_instr, NOP_INSTR);
    chk("rst.pc", bus.id_pc, 32'd0);
    chk("rst.pc4", bus.id_pc_plus4, 32'd4);
    chk("rst.addr", bus.imem_addr, 32'd0);

    // Reset release, free running.
    bus.redirect = 1'b0;
    rst = 1'b0;
    #1 chk("run.addr0", bus.imem_addr, 32'd0);
    tick(); check_id("run.e1"); chk("run.addr1", bus.imem_addr, 32'd4);
    tick(); check_id("run.e2"); chk("run.addr2", bus.imem_addr, 32'd8);
    chk("run.e2.word", bus.id_instr, 32'h2108_0008);
    tick(); check_id("run.e3");
    chk("run.e3.word", bus.id_instr, 32'h2129_0009);
    chk("run.e3.pc4", bus.id_pc_plus4, 32'd8);

    // Three-cycle stall while id_pc=4.
    bus.stall = 1'b1;
    #1 chk("stall.addr", bus.imem_addr, 32'd8);
    for (int i = 0; i < 3; i++) begin
      tick(); check_id("stall.hold"); chk("stall.addr", bus.imem_addr, 32'd8);
    end
    bus.stall = 1'b0;
    tick(); check_id("stall.rel1"); chk("stall.rel1.pc", bus.id_pc, 32'd8);
    tick(); check_id("stall.rel2"); chk("stall.rel2.pc", bus.id_pc, 32'd12);

    // Branch redirect to 20: two bubbles then the target word.
    bus.redirect = 1'b1; bus.redirect_target = 32'd20;
    tick(); check_id("br.e0");
    bus.redirect = 1'b0;
    tick(); check_id("br.e1");
    tick(); check_id("br.e2");
    chk("br.word", bus.id_instr, 32'h8D28_0018);
    chk("br.pc", bus.id_pc, 32'd20);

    // Redirect to unaligned 39 during a stall.
    bus.stall = 1'b1;
    tick(); check_id("brst.s");
    bus.redirect = 1'b1; bus.redirect_target = 32'd39;
    tick(); check_id("brst.e0");
    bus.redirect = 1'b0; bus.stall = 1'b0;
    tick(); check_id("brst.e1");
    tick(); check_id("brst.e2");
    chk("brst.word", bus.id_instr, 32'hAD68_0018);
    chk("brst.pc", bus.id_pc, 32'd36);

    // Reset mid-stream with stall held.
    tick(); check_id("mid.run");
    bus.stall = 1'b1; rst = 1'b1;
    #1 chk("mid.addr.comb", bus.imem_addr, 32'd0);
    tick(); check_id("mid.rst");
    chk("mid.addr", bus.imem_addr, 32'd0);
    rst = 1'b0; bus.stall = 1'b0;
    tick(); check_id("mid.e1");
    tick(); check_id("mid.e2");
    chk("mid.word", bus.id_instr, 32'h2108_0008);

    // Address wrap at the top of the space.
    bus.redirect = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
    tick(); check_id("wrap.e0");
    bus.redirect = 1'b0;
    chk("wrap.addr.top", bus.imem_addr, 32'hFFFF_FFFC);
    tick(); check_id("wrap.e1");
    chk("wrap.addr.zero", bus.imem_addr, 32'd0);
    tick(); check_id("wrap.e2");
    chk("wrap.pc4", bus.id_pc_plus4, 32'd0);
    tick(); check_id("wrap.e3");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 50) == 0;
      bus.stall = ($urandom % 10) < 3;
      bus.redirect = ($urandom % 8) == 0;
      bus.redirect_target = ($urandom % 4 != 0) ? 32'($urandom_range(0, 63)) : $urandom;
      tick(); check_id("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
